// File: rtl/flappy_pkg.sv
// Shared types and helpers for the bird-column engine.
package flappy_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLY     = 2'd1,
        CRASHED = 2'd2
    } bird_state_t;

    // Index width for a count of n items, never narrower than one bit.
    function automatic int row_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bird_fall_timer.sv
// Gravity divider: counts flapless game ticks and emits drop on the tick that wraps the count.
module bird_fall_timer
    import flappy_pkg::*;
#(
    parameter int FALL_DIV = 2
) (
    input  logic clk,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic drop
);

    localparam int CW = row_w(FALL_DIV);

    logic [CW-1:0] fall_cnt_r;
    logic          wrap_s;

    assign wrap_s = (fall_cnt_r == CW'(FALL_DIV - 1));
    assign drop   = en & wrap_s & ~clr;

    // Tick counter: cleared by a flap tick, advanced and wrapped by flapless ticks.
    always_ff @(posedge clk) begin
        if (RST) begin
            fall_cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            fall_cnt_r <= {CW{1'b0}};
        end else if (en) begin
            if (wrap_s) begin
                fall_cnt_r <= {CW{1'b0}};
            end else begin
                fall_cnt_r <= fall_cnt_r + CW'(1'b1);
            end
        end else begin
            fall_cnt_r <= fall_cnt_r;
        end
    end

endmodule

// File: rtl/bird_column.sv
// Bird-position engine for one LED-matrix column: row index, flap/gravity motion,
// pipe/ground/kill collision and a one-hot pixel drive.
module bird_column
    import flappy_pkg::*;
#(
    parameter int ROWS      = 8,
    parameter int START_ROW = 4,
    parameter int FLAP_ROWS = 1,
    parameter int FALL_DIV  = 2
) (
    input  logic                   clk,
    input  logic                   RST,
    input  logic                   tick,
    input  logic                   flap,
    input  logic                   dead,
    input  logic [ROWS-1:0]        pipe_col,
    output logic [ROWS-1:0]        light,
    output logic [row_w(ROWS)-1:0] row,
    output logic                   flying,
    output logic                   crash
);

    localparam int RW = row_w(ROWS);

    if (ROWS < 2) begin : g_bad_rows
        $error("bird_column: ROWS must be at least 2");
    end
    if ((START_ROW < 0) || (START_ROW >= ROWS)) begin : g_bad_start
        $error("bird_column: START_ROW must lie in 0..ROWS-1");
    end
    if ((FLAP_ROWS < 1) || (FLAP_ROWS > ROWS - 1)) begin : g_bad_flap
        $error("bird_column: FLAP_ROWS must lie in 1..ROWS-1");
    end
    if (FALL_DIV < 1) begin : g_bad_div
        $error("bird_column: FALL_DIV must be at least 1");
    end

    bird_state_t   state_r, state_s;
    logic [RW-1:0] row_r, row_s;
    logic [ROWS-1:0] light_r;
    logic          crash_r;
    logic          flap_pend_r, flap_pend_s;
    logic          flap_eff_s;
    logic          in_fly_s;
    logic          drop_s;
    logic          ground_s;
    logic          hit_s;
    logic [RW:0]   climb_s;
    logic [RW-1:0] climb_sat_s;

    assign flap_eff_s = flap | flap_pend_r;
    assign in_fly_s   = (state_r == FLY);

    bird_fall_timer #(
        .FALL_DIV (FALL_DIV)
    ) u_fall_timer (
        .clk  (clk),
        .RST  (RST),
        .clr  (in_fly_s & tick & flap_eff_s),
        .en   (in_fly_s & tick & ~flap_eff_s),
        .drop (drop_s)
    );

    // Climb is formed one bit wider so the ceiling saturates instead of wrapping.
    assign climb_s     = {1'b0, row_r} + (RW+1)'(FLAP_ROWS);
    assign climb_sat_s = (climb_s > (RW+1)'(ROWS - 1)) ? RW'(ROWS - 1) : climb_s[RW-1:0];
    assign ground_s    = drop_s & (row_r == {RW{1'b0}});
    assign hit_s       = pipe_col[row_r] | dead | ground_s;

    // Next-state, next-row and pending-flap decision.
    always_comb begin
        state_s     = state_r;
        row_s       = row_r;
        flap_pend_s = flap_pend_r;
        case (state_r)
            IDLE: begin
                if (dead) begin
                    state_s     = CRASHED;
                    flap_pend_s = flap_eff_s;
                end else if (flap_eff_s) begin
                    state_s     = FLY;
                    flap_pend_s = 1'b0;
                end else begin
                    flap_pend_s = flap_pend_r;
                end
            end
            FLY: begin
                if (hit_s) begin
                    state_s = CRASHED;
                end else if (tick) begin
                    flap_pend_s = 1'b0;
                    if (flap_eff_s) begin
                        row_s = climb_sat_s;
                    end else if (drop_s) begin
                        row_s = row_r - RW'(1'b1);
                    end else begin
                        row_s = row_r;
                    end
                end else begin
                    flap_pend_s = flap_pend_r | flap;
                end
            end
            CRASHED: begin
                state_s = CRASHED;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, position, pixel and crash-pulse registers.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_r     <= IDLE;
            row_r       <= RW'(START_ROW);
            light_r     <= {{(ROWS-1){1'b0}}, 1'b1} << START_ROW;
            crash_r     <= 1'b0;
            flap_pend_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            row_r       <= row_s;
            light_r     <= {{(ROWS-1){1'b0}}, 1'b1} << row_s;
            crash_r     <= (state_r != CRASHED) && (state_s == CRASHED);
            flap_pend_r <= flap_pend_s;
        end
    end

    assign light  = light_r;
    assign row    = row_r;
    assign flying = in_fly_s;
    assign crash  = crash_r;

endmodule

// File: tb/tb_bird_column.sv
// Random and directed bench for bird_column: two instances (FLAP_ROWS 1 and 3) against a behavioural model.
module tb_bird_column;

    localparam int FD = 2;

    logic       clk;
    logic       RST;
    logic       tick;
    logic       flap;
    logic       dead;
    logic [7:0] pipe_col;
    logic [7:0] light1, light3;
    logic [2:0] row1, row3;
    logic       flying1, flying3;
    logic       crash1, crash3;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    // model: st 0 = waiting, 1 = airborne, 2 = crashed
    int m_st[2]    = '{0, 0};
    int m_row[2]   = '{4, 4};
    int m_cnt[2]   = '{0, 0};
    bit m_pend[2]  = '{1'b0, 1'b0};
    bit m_crash[2] = '{1'b0, 1'b0};

    bird_column #(.ROWS(8), .START_ROW(4), .FLAP_ROWS(1), .FALL_DIV(FD)) u1 (
        .clk(clk), .RST(RST), .tick(tick), .flap(flap), .dead(dead), .pipe_col(pipe_col),
        .light(light1), .row(row1), .flying(flying1), .crash(crash1)
    );

    bird_column #(.ROWS(8), .START_ROW(4), .FLAP_ROWS(3), .FALL_DIV(FD)) u3 (
        .clk(clk), .RST(RST), .tick(tick), .flap(flap), .dead(dead), .pipe_col(pipe_col),
        .light(light3), .row(row3), .flying(flying3), .crash(crash3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: game rules applied once per clock to both birds.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            automatic int fr = (k == 0) ? 1 : 3;
            automatic bit fe = flap || m_pend[k];
            automatic bit ground;
            m_crash[k] = 1'b0;
            if (RST) begin
                m_st[k] = 0; m_row[k] = 4; m_cnt[k] = 0; m_pend[k] = 1'b0;
            end else if (m_st[k] == 0) begin
                if (dead) begin
                    m_st[k] = 2; m_crash[k] = 1'b1;
                end else if (fe) begin
                    m_st[k] = 1; m_pend[k] = 1'b0;
                end
            end else if (m_st[k] == 1) begin
                ground = tick && !fe && (m_cnt[k] == FD - 1) && (m_row[k] == 0);
                if (pipe_col[m_row[k]] || dead || ground) begin
                    m_st[k] = 2; m_crash[k] = 1'b1;
                end else if (tick) begin
                    m_pend[k] = 1'b0;
                    if (fe) begin
                        m_row[k] = (m_row[k] + fr > 7) ? 7 : m_row[k] + fr;
                        m_cnt[k] = 0;
                    end else if (m_cnt[k] == FD - 1) begin
                        m_cnt[k] = 0;
                        m_row[k] = m_row[k] - 1;
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                end else if (flap) begin
                    m_pend[k] = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("u1.light",  int'(light1),  1 << m_row[0]);
            chk("u1.row",    int'(row1),    m_row[0]);
            chk("u1.flying", int'(flying1), int'(m_st[0] == 1));
            chk("u1.crash",  int'(crash1),  int'(m_crash[0]));
            chk("u3.light",  int'(light3),  1 << m_row[1]);
            chk("u3.row",    int'(row3),    m_row[1]);
            chk("u3.flying", int'(flying3), int'(m_st[1] == 1));
            chk("u3.crash",  int'(crash3),  int'(m_crash[1]));
        end
    end

    task automatic cyc(input bit t, input bit f, input bit d, input logic [7:0] p, input bit r);
        tick = t; flap = f; dead = d; pipe_col = p; RST = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        RST = 1'b1; tick = 1'b0; flap = 1'b0; dead = 1'b0; pipe_col = 8'h00;
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        cmp_en = 1'b1;
        chk("reset_row", int'(row1), 4);
        chk("reset_light", int'(light1), 8'h10);
        chk("reset_crash", int'(crash1), 0);
        chk("reset_flying", int'(flying1), 0);

        repeat (3) cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("idle_ticks_row", int'(row1), 4);
        chk("idle_ticks_light", int'(light1), 8'h10);
        chk("idle_ticks_flying", int'(flying1), 0);

        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("flap_to_fly", int'(flying1), 1);
        chk("flap_to_fly_row", int'(row1), 4);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("fall_tick1", int'(row1), 4);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("fall_tick2", int'(row1), 3);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("fall_tick4", int'(row1), 2);

        // flap lands mid-interval, consumed by a tick five cycles later
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("pend_flap_u1", int'(row1), 3);
        chk("pend_flap_u3", int'(row3), 5);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("pend_cleared_cnt_zero", int'(row1), 3);
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("flap3_saturate_u3", int'(row3), 7);
        chk("flap1_u1", int'(row1), 4);
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("climb_to_top", int'(row1), 7);
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("ceiling_row", int'(row1), 7);
        chk("ceiling_no_crash", int'(crash1), 0);
        chk("ceiling_flying", int'(flying1), 1);

        repeat (14) cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("descend_row0", int'(row1), 0);
        chk("descend_flying", int'(flying1), 1);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("row0_pre_crash", int'(crash1), 0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("ground_crash", int'(crash1), 1);
        chk("ground_light", int'(light1), 8'h01);
        chk("ground_flying", int'(flying1), 0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("crash_one_cycle", int'(crash1), 0);
        cyc(1'b1, 1'b1, 1'b0, 8'hff, 1'b0);
        chk("crashed_frozen", int'(row1), 0);

        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h10, 1'b0);
        chk("pipe_crash", int'(crash1), 1);
        chk("pipe_crash_row", int'(row1), 4);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("rst_after_crash_row", int'(row1), 4);
        chk("rst_after_crash_crash", int'(crash1), 0);
        chk("rst_after_crash_flying", int'(flying1), 0);

        for (int i = 0; i < 4000; i++) begin
            automatic bit both_dead = (m_st[0] == 2) && (m_st[1] == 2);
            automatic bit r = both_dead ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 199) == 0);
            automatic logic [7:0] p = 8'h00;
            if ($urandom_range(0, 7) == 0) p = 8'h01 << $urandom_range(0, 7);
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
                $urandom_range(0, 299) == 0, p, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
